hop_rst_sequencer: RTL and testbench



---
 rtl/hop_seq_pkg.sv | 25 ++
 rtl/hop_gap_timer.sv | 31 +++
 rtl/hop_rst_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_hop_rst_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/hop_seq_pkg.sv
// Shared types and defaults for the hop reset/launch sequencer.
//   state_t       : sequencer FSM states
//   *_DEF         : default hold, expected latency and timeout
//   clamp_gap()   : forces a zero release gap up to one cycle
package hop_seq_pkg;

  localparam int unsigned HOLD_CYC_DEF = 4;
  localparam int unsigned EXP_LAT_DEF  = 5;
  localparam int unsigned TMO_DEF      = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    RELEASE = 3'd2,
    LAUNCH  = 3'd3,
    WAIT    = 3'd4,
    FIN     = 3'd5
  } state_t;

  // A gap of zero would never expire the down-counter; treat it as one.
  function automatic int unsigned clamp_gap(input int unsigned g);
    return (g == 0) ? 1 : g;
  endfunction

endpackage

// File: rtl/hop_gap_timer.sv
// Loadable down-counter with a one-cycle expire flag.
//   clock0, rst1 : clock, async active-high reset
//   load, val    : load the counter with val (load wins over counting)
//   expire_c     : high during the last counted cycle (count == 1)
// Loading N makes expire_c high in the N-th cycle after the load edge.
module hop_gap_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clock0,
  input  logic         rst1,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire_c = (cnt == W'(1));

endmodule

// File: rtl/hop_rst_sequencer.sv
// Reset-release and launch sequencer for a multi-hop flop chain.
//   clock0, rst1 : clock, async active-high reset
//   go, gap      : run request (IDLE only) and release spacing (0 -> 1)
//   abort        : abandon the current run
//   chain_out    : last-stage output of the chain
//   stage_rst    : per-stage resets, bit NSTG-1 most downstream
//   start        : one-cycle launch pulse
//   busy, done   : run in progress / completion pulse
//   pass, lat    : result and measured latency, valid with done
module hop_rst_sequencer
  import hop_seq_pkg::*;
#(
  parameter int unsigned NSTG     = 3,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned GAP_W    = 4,
  parameter int unsigned EXP_LAT  = EXP_LAT_DEF,
  parameter int unsigned TMO      = TMO_DEF,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             go,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  input  logic             chain_out,
  output logic [NSTG-1:0]  stage_rst,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] lat
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int unsigned TMR_W  = (GAP_W > HOLD_W) ? GAP_W : HOLD_W;
  localparam int unsigned IDX_W  = (NSTG > 1) ? $clog2(NSTG) : 1;

  state_t             state, state_d;
  logic [NSTG-1:0]    stage_rst_d;
  logic               start_d, busy_d, done_d, pass_d;
  logic [CNT_W-1:0]   lat_d;
  logic [GAP_W-1:0]   gap_q, gap_q_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               tmr_load_c;
  logic [TMR_W-1:0]   tmr_val_c;
  logic               tmr_expire_c;

  // Shared timer: HOLD_CYC in ASSERT, gap_q between releases.
  hop_gap_timer #(.W(TMR_W)) u_timer (
    .clock0   (clock0),
    .rst1     (rst1),
    .load     (tmr_load_c),
    .val      (tmr_val_c),
    .expire_c (tmr_expire_c)
  );

  // State and registered outputs.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state     <= IDLE;
      stage_rst <= '1;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      lat       <= '0;
      gap_q     <= GAP_W'(1);
      cnt       <= '0;
      idx       <= '0;
    end else begin
      state     <= state_d;
      stage_rst <= stage_rst_d;
      start     <= start_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      lat       <= lat_d;
      gap_q     <= gap_q_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
    end
  end

  // Next-state and next-output logic; abort has priority in active states.
  always_comb begin
    state_d     = state;
    stage_rst_d = stage_rst;
    start_d     = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    pass_d      = pass;
    lat_d       = lat;
    gap_q_d     = gap_q;
    cnt_d       = cnt;
    idx_d       = idx;
    tmr_load_c  = 1'b0;
    tmr_val_c   = '0;

    unique case (state)
      IDLE: begin
        if (go) begin
          state_d     = ASSERT;
          gap_q_d     = GAP_W'(clamp_gap(32'(gap)));
          stage_rst_d = '1;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          lat_d       = '0;
          tmr_load_c  = 1'b1;
          tmr_val_c   = TMR_W'(HOLD_CYC);
        end
      end

      ASSERT: begin
        if (abort) begin
          state_d     = FIN;
          stage_rst_d = '1;
          pass_d      = 1'b0;
          lat_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (tmr_expire_c) begin
          state_d    = RELEASE;
          idx_d      = IDX_W'(NSTG - 1);
          tmr_load_c = 1'b1;
          tmr_val_c  = TMR_W'(gap_q);
        end
      end

      RELEASE: begin
        if (abort) begin
          state_d     = FIN;
          stage_rst_d = '1;
          pass_d      = 1'b0;
          lat_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (tmr_expire_c) begin
          stage_rst_d[idx] = 1'b0;
          if (idx == '0) begin
            // Launch lands in the cycle the last reset is seen released.
            state_d = LAUNCH;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            idx_d      = idx - IDX_W'(1);
            tmr_load_c = 1'b1;
            tmr_val_c  = TMR_W'(gap_q);
          end
        end
      end

      LAUNCH: begin
        if (abort || chain_out) begin
          // chain_out already high at launch means the chain was dirty.
          state_d = FIN;
          if (abort) begin
            stage_rst_d = '1;
          end
          pass_d = 1'b0;
          lat_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end

      WAIT: begin
        if (abort) begin
          state_d     = FIN;
          stage_rst_d = '1;
          pass_d      = 1'b0;
          lat_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (chain_out) begin
          state_d = FIN;
          lat_d   = cnt;
          pass_d  = (cnt == CNT_W'(EXP_LAT));
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cnt >= CNT_W'(TMO)) begin
          state_d = FIN;
          lat_d   = CNT_W'(TMO);
          pass_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cnt != '1) begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hop_rst_sequencer.sv
// Directed bench for hop_rst_sequencer with a shift-register chain model.
module tb_hop_rst_sequencer;

  logic       clock0 = 1'b0;
  logic       rst1;
  logic       go;
  logic [3:0] gap;
  logic       abort;
  logic       chain_out;
  logic [2:0] stage_rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] lat;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         mode   = 0;    // 0: tied low, 1: tied high, 4/5: N-flop delay of start
  logic [4:0] sr     = '0;

  hop_rst_sequencer dut (
    .clock0    (clock0),
    .rst1      (rst1),
    .go        (go),
    .gap       (gap),
    .abort     (abort),
    .chain_out (chain_out),
    .stage_rst (stage_rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .lat       (lat)
  );

  always #5 clock0 = ~clock0;

  always @(posedge clock0) sr <= {sr[3:0], start};

  always_comb begin
    case (mode)
      1:       chain_out = 1'b1;
      4:       chain_out = sr[3];
      5:       chain_out = sr[4];
      default: chain_out = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock0);
    #1;
  endtask

  // One full run from go; k counts cycles after the go edge.
  // Releases land at k = 5+g, 5+2g, 5+3g; launch at k = 5+3g.
  task automatic run(input int g_in, input int md, input int abort_k, input int go_k,
                     input bit go_fin, input int exp_k, input bit exp_pass, input int exp_lat);
    int         g;
    int         l_k;
    int         nrel;
    logic [2:0] e;
    g    = (g_in == 0) ? 1 : g_in;
    l_k  = 5 + 3 * g;
    mode = md;
    gap  = 4'(g_in);
    go   = 1'b1;
    for (int k = 1; k <= exp_k; k++) begin
      tick();
      nrel = 0;
      for (int i = 1; i <= 3; i++) if (5 + i * g <= k) nrel++;
      e = 3'b111;
      e = e >> nrel;
      if (abort_k != 0 && k > abort_k) e = 3'b111;
      check($sformatf("stage_rst@%0d", k), 32'(stage_rst), 32'(e));
      check($sformatf("busy@%0d", k), 32'(busy), 32'(k < exp_k));
      check($sformatf("done@%0d", k), 32'(done), 32'(k == exp_k));
      if (k <= l_k + 1) check($sformatf("start@%0d", k), 32'(start), 32'(k == l_k));
      if (k == 1) begin
        check("pass_clr", 32'(pass), 32'd0);
        check("lat_clr", 32'(lat), 32'd0);
      end
      go    = (k == go_k) || (go_fin && k == exp_k);
      abort = (k == abort_k);
    end
    check("pass", 32'(pass), 32'(exp_pass));
    check("lat", 32'(lat), 32'(exp_lat));
    tick();
    go    = 1'b0;
    abort = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("hold_pass", 32'(pass), 32'(exp_pass));
    check("hold_lat", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    rst1  = 1'b1;
    go    = 1'b0;
    gap   = '0;
    abort = 1'b0;
    #12;
    check("rst_stage_rst", 32'(stage_rst), 32'd7);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_lat", 32'(lat), 32'd0);
    tick();
    rst1 = 1'b0;
    tick();

    // Nominal 5-hop chain, then wrong latency and timeout.
    run(2, 5, 0, 0, 1'b0, 17, 1'b1, 5);
    run(2, 4, 0, 0, 1'b0, 16, 1'b0, 4);
    run(2, 0, 0, 0, 1'b0, 27, 1'b0, 15);

    // gap=0 behaves as 1; chain_out already high at launch.
    run(0, 1, 0, 0, 1'b0, 9, 1'b0, 0);

    // abort in the cycle chain_out rises (launch at k=8, rise at k=13).
    run(1, 5, 13, 0, 1'b0, 14, 1'b0, 0);

    // Async reset mid-RELEASE.
    mode = 5;
    gap  = 4'd2;
    go   = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 2; k <= 8; k++) tick();
    check("mid_stage_rst", 32'(stage_rst), 32'd3);
    rst1 = 1'b1;
    #1;
    check("arst_stage_rst", 32'(stage_rst), 32'd7);
    check("arst_busy", 32'(busy), 32'd0);
    #1;
    rst1 = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_stage", 32'(stage_rst), 32'd7);
    run(2, 5, 0, 0, 1'b0, 17, 1'b1, 5);

    // go during WAIT and in FIN is ignored; next go clears pass/lat.
    run(2, 5, 0, 13, 1'b1, 17, 1'b1, 5);
    tick();
    check("no_restart_busy", 32'(busy), 32'd0);
    run(3, 5, 0, 0, 1'b0, 20, 1'b1, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
